// File: rtl/reg_wb_queue_pkg.sv
// Shared widths, default sizing and the writeback queue entry type for the
// register-file port C write path.
package reg_wb_queue_pkg;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 7;
  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_QDEPTH   = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_queue_fifo.sv
// In-order writeback queue: two push ports per cycle (port 0 lands first),
// one pop per cycle, occupancy exported for ready generation.
module wb_fifo
  import reg_wb_queue_pkg::*;
#(
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         push0,
  input  wb_entry_t                    din0,
  input  logic                         push1,
  input  wb_entry_t                    din1,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic [$clog2(QDEPTH+1)-1:0]  cnt
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);

  wb_entry_t         mem_q [QDEPTH];
  wb_entry_t         mem_d [QDEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wr1_idx;

  // Next-state for storage, pointers and occupancy; port 1 writes behind port 0.
  always_comb begin
    mem_d    = mem_q;
    wr1_idx  = wr_ptr_q + PW'(push0);
    if (push0) begin
      mem_d[wr_ptr_q] = din0;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    if (push1) begin
      mem_d[wr1_idx] = din1;
    end else begin
      mem_d[wr1_idx] = mem_d[wr1_idx];
    end
    wr_ptr_d = wr_ptr_q + PW'(push0) + PW'(push1);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  // Pointer/occupancy flops; payload storage needs no reset.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
    if (Reset) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      cnt_q    <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/reg_wb_queue.sv
// Register-file port C write master: arbitrates ALU/load writebacks into an
// in-order queue, issues one registered write per cycle, tracks pending writes.
module reg_wb_queue
  import reg_wb_queue_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int QDEPTH   = DEF_QDEPTH
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Alu_Valid,
  output logic              Alu_Ready,
  input  logic [ADDR_W-1:0] Alu_Addr,
  input  logic [DATA_W-1:0] Alu_Data,
  input  logic              Ld_Valid,
  output logic              Ld_Ready,
  input  logic [ADDR_W-1:0] Ld_Addr,
  input  logic [DATA_W-1:0] Ld_Data,
  output logic [ADDR_W-1:0] Addr_C,
  output logic [DATA_W-1:0] RegPort_C,
  output logic              Write_RegC,
  input  logic [ADDR_W-1:0] Query_A,
  input  logic [ADDR_W-1:0] Query_B,
  output logic              Pend_A,
  output logic              Pend_B,
  output logic              Err_Addr
);

  localparam int CW  = $clog2(QDEPTH+1);
  localparam int PCW = $clog2(QDEPTH+2);
  localparam int RW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [CW-1:0]     cnt;
  wb_entry_t         head, alu_ent, ld_ent;
  logic              alu_ready, ld_ready, alu_legal, ld_legal;
  logic              alu_hs, ld_hs, push_alu, push_ld, pop;
  logic              pend_a, pend_b;

  logic              write_c_q, write_c_d;
  logic [ADDR_W-1:0] addr_c_q, addr_c_d;
  logic [DATA_W-1:0] data_c_q, data_c_d;
  logic              err_q, err_d;
  logic [PCW-1:0]    pcnt_q [NUM_REGS];
  logic [PCW-1:0]    pcnt_d [NUM_REGS];

  // Readiness uses start-of-cycle occupancy only; a load alongside an ALU request needs two slots.
  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (!Reset) begin
      alu_ready = (cnt <= CW'(QDEPTH-1));
      if (Alu_Valid) begin
        ld_ready = (cnt <= CW'(QDEPTH-2));
      end else begin
        ld_ready = (cnt <= CW'(QDEPTH-1));
      end
    end else begin
      alu_ready = 1'b0;
      ld_ready  = 1'b0;
    end
  end

  assign alu_legal = (Alu_Addr < ADDR_W'(NUM_REGS));
  assign ld_legal  = (Ld_Addr  < ADDR_W'(NUM_REGS));
  assign alu_hs    = Alu_Valid & alu_ready;
  assign ld_hs     = Ld_Valid & ld_ready;
  assign push_alu  = alu_hs & alu_legal;
  assign push_ld   = ld_hs & ld_legal;
  assign pop       = (cnt != CW'(0));
  assign alu_ent   = '{addr: Alu_Addr, data: Alu_Data};
  assign ld_ent    = '{addr: Ld_Addr,  data: Ld_Data};

  wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push0 (push_alu),
    .din0  (alu_ent),
    .push1 (push_ld),
    .din1  (ld_ent),
    .pop   (pop),
    .head  (head),
    .cnt   (cnt)
  );

  // Port C next state: write the queue head when one is present, otherwise hold address/data.
  always_comb begin
    write_c_d = 1'b0;
    addr_c_d  = addr_c_q;
    data_c_d  = data_c_q;
    if (pop) begin
      write_c_d = 1'b1;
      addr_c_d  = head.addr;
      data_c_d  = head.data;
    end else begin
      write_c_d = 1'b0;
    end
    err_d = err_q | (alu_hs & ~alu_legal) | (ld_hs & ~ld_legal);
  end

  // Pending-write counters: count accepts, retire on the cycle port C writes that register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pcnt_d[r] = pcnt_q[r]
                + PCW'(push_alu && (Alu_Addr == ADDR_W'(r)))
                + PCW'(push_ld  && (Ld_Addr  == ADDR_W'(r)))
                - PCW'(write_c_q && (addr_c_q == ADDR_W'(r)));
    end
  end

  // Operand hazard lookup; out-of-range queries never report pending.
  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    if (Query_A < ADDR_W'(NUM_REGS)) begin
      pend_a = (pcnt_q[Query_A[RW-1:0]] != PCW'(0));
    end else begin
      pend_a = 1'b0;
    end
    if (Query_B < ADDR_W'(NUM_REGS)) begin
      pend_b = (pcnt_q[Query_B[RW-1:0]] != PCW'(0));
    end else begin
      pend_b = 1'b0;
    end
  end

  // Output, error and scoreboard state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      write_c_q <= 1'b0;
      addr_c_q  <= ADDR_W'(0);
      data_c_q  <= DATA_W'(0);
      err_q     <= 1'b0;
      pcnt_q    <= '{default: PCW'(0)};
    end else begin
      write_c_q <= write_c_d;
      addr_c_q  <= addr_c_d;
      data_c_q  <= data_c_d;
      err_q     <= err_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign Alu_Ready  = alu_ready;
  assign Ld_Ready   = ld_ready;
  assign Write_RegC = write_c_q;
  assign Addr_C     = addr_c_q;
  assign RegPort_C  = data_c_q;
  assign Err_Addr   = err_q;
  assign Pend_A     = pend_a;
  assign Pend_B     = pend_b;

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: hand-computed vector table plus a queue-based
// reference model and a scoreboard of accepted writes checked at port C.
module tb_reg_wb_queue;
  import reg_wb_queue_pkg::*;

  localparam int NREG = 4;
  localparam int QD   = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Alu_Valid, Ld_Valid;
  logic              Alu_Ready, Ld_Ready;
  logic [ADDR_W-1:0] Alu_Addr, Ld_Addr, Query_A, Query_B, Addr_C;
  logic [DATA_W-1:0] Alu_Data, Ld_Data, RegPort_C;
  logic              Write_RegC, Pend_A, Pend_B, Err_Addr;

  always #5 Clk = ~Clk;

  reg_wb_queue #(.NUM_REGS(NREG), .QDEPTH(QD)) dut (
    .Clk(Clk), .Reset(Reset),
    .Alu_Valid(Alu_Valid), .Alu_Ready(Alu_Ready), .Alu_Addr(Alu_Addr), .Alu_Data(Alu_Data),
    .Ld_Valid(Ld_Valid), .Ld_Ready(Ld_Ready), .Ld_Addr(Ld_Addr), .Ld_Data(Ld_Data),
    .Addr_C(Addr_C), .RegPort_C(RegPort_C), .Write_RegC(Write_RegC),
    .Query_A(Query_A), .Query_B(Query_B), .Pend_A(Pend_A), .Pend_B(Pend_B),
    .Err_Addr(Err_Addr)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int n_wr     = 0;

  wb_entry_t         mq[$];
  wb_entry_t         sb[$];
  int                mpcnt[NREG] = '{default: 0};
  logic              mwr   = 1'b0;
  logic [ADDR_W-1:0] maddr = '0;
  logic [DATA_W-1:0] mdata = '0;
  logic              merr  = 1'b0;

  typedef struct {
    logic              av;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ad;
    logic              lv;
    logic [ADDR_W-1:0] la;
    logic [DATA_W-1:0] ld;
    logic [ADDR_W-1:0] qa;
    logic [ADDR_W-1:0] qb;
    logic              ewr;
    logic [ADDR_W-1:0] eaddr;
    logic [DATA_W-1:0] edata;
    logic              epa;
    logic              epb;
    logic              eerr;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_pend(input logic [ADDR_W-1:0] q);
    if (q < ADDR_W'(NREG)) return mpcnt[q[1:0]] != 0;
    return 1'b0;
  endfunction

  task automatic accept(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_entry_t e;
    if (a < ADDR_W'(NREG)) begin
      e.addr = a;
      e.data = d;
      mq.push_back(e);
      sb.push_back(e);
      mpcnt[a[1:0]]++;
      n_acc++;
    end else begin
      merr = 1'b1;
    end
  endtask

  task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    Alu_Valid = av; Alu_Addr = aa; Alu_Data = ad;
    Ld_Valid  = lv; Ld_Addr  = la; Ld_Data  = ld;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, check registered outputs.
  task automatic cycle();
    bit ar, lr;
    wb_entry_t e;
    @(negedge Clk);
    ar = !Reset && (mq.size() <= QD-1);
    lr = !Reset && (Alu_Valid ? (mq.size() <= QD-2) : (mq.size() <= QD-1));
    chk("alu_ready", 32'(Alu_Ready), 32'(ar));
    chk("ld_ready",  32'(Ld_Ready),  32'(lr));
    chk("pend_a",    32'(Pend_A),    32'(m_pend(Query_A)));
    chk("pend_b",    32'(Pend_B),    32'(m_pend(Query_B)));
    @(posedge Clk);
    if (Reset) begin
      mq.delete(); sb.delete();
      mpcnt = '{default: 0};
      mwr = 1'b0; maddr = '0; mdata = '0; merr = 1'b0;
    end else begin
      if (mwr) mpcnt[maddr[1:0]]--;
      if (mq.size() > 0) begin
        e = mq.pop_front();
        mwr = 1'b1; maddr = e.addr; mdata = e.data;
      end else begin
        mwr = 1'b0;
      end
      if (Alu_Valid && ar) accept(Alu_Addr, Alu_Data);
      if (Ld_Valid && lr)  accept(Ld_Addr, Ld_Data);
    end
    #1;
    chk("write_regc", 32'(Write_RegC), 32'(mwr));
    chk("addr_c",     32'(Addr_C),     32'(maddr));
    chk("regport_c",  32'(RegPort_C),  32'(mdata));
    chk("err_addr",   32'(Err_Addr),   32'(merr));
    if (Write_RegC === 1'b1) begin
      n_wr++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_addr", 32'(Addr_C),    32'(e.addr));
        chk("sb_data", 32'(RegPort_C), 32'(e.data));
      end
    end
  endtask

  initial begin
    int k;
    // av aa ad lv la ld qa qb | ewr eaddr edata epa epb eerr
    tbl[0]  = '{1'b1, 7'd2, 16'h1234, 1'b0, 7'd0, 16'h0000, 7'd2, 7'd1, 1'b0, 7'd0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 16'h0000, 7'd2, 7'd1, 1'b1, 7'd2, 16'h1234, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 7'd1, 16'hAAAA, 1'b1, 7'd1, 16'h5555, 7'd2, 7'd1, 1'b0, 7'd2, 16'h1234, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 16'h0000, 7'd2, 7'd1, 1'b1, 7'd1, 16'hAAAA, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 16'h0000, 7'd2, 7'd1, 1'b1, 7'd1, 16'h5555, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 16'h0000, 7'd2, 7'd1, 1'b0, 7'd1, 16'h5555, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 7'd0, 16'h0000, 1'b1, 7'd5, 16'h7777, 7'd2, 7'd1, 1'b0, 7'd1, 16'h5555, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 16'h0000, 7'd2, 7'd1, 1'b0, 7'd1, 16'h5555, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 7'd3, 16'h0303, 1'b0, 7'd0, 16'h0000, 7'd3, 7'd1, 1'b0, 7'd1, 16'h5555, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 16'h0000, 7'd3, 7'd1, 1'b1, 7'd3, 16'h0303, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 7'd3, 16'h0404, 1'b0, 7'd0, 16'h0000, 7'd3, 7'd1, 1'b0, 7'd3, 16'h0303, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 16'h0000, 7'd3, 7'd1, 1'b1, 7'd3, 16'h0404, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 16'h0000, 7'd3, 7'd1, 1'b0, 7'd3, 16'h0404, 1'b0, 1'b0, 1'b1};

    drive(1'b0, '0, '0, 1'b0, '0, '0);
    Query_A = 7'd2; Query_B = 7'd1;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("rst_write_regc", 32'(Write_RegC), 32'd0);
    chk("rst_addr_c",     32'(Addr_C),     32'd0);
    chk("rst_regport_c",  32'(RegPort_C),  32'd0);
    chk("rst_err_addr",   32'(Err_Addr),   32'd0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld);
      Query_A = tbl[i].qa;
      Query_B = tbl[i].qb;
      cycle();
      chk($sformatf("vec%0d_wr", i),   32'(Write_RegC), 32'(tbl[i].ewr));
      chk($sformatf("vec%0d_addr", i), 32'(Addr_C),     32'(tbl[i].eaddr));
      chk($sformatf("vec%0d_data", i), 32'(RegPort_C),  32'(tbl[i].edata));
      chk($sformatf("vec%0d_pa", i),   32'(Pend_A),     32'(tbl[i].epa));
      chk($sformatf("vec%0d_pb", i),   32'(Pend_B),     32'(tbl[i].epb));
      chk($sformatf("vec%0d_err", i),  32'(Err_Addr),   32'(tbl[i].eerr));
    end

    // Sustained burst: both sources held valid until at least 8 writes are accepted.
    Query_A = 7'd0; Query_B = 7'd1;
    n_acc = 0; n_wr = 0; k = 0;
    while (n_acc < 8 && k < 40) begin
      drive(1'b1, 7'(k % 4), 16'hB000 + 16'(k), 1'b1, 7'((k + 1) % 4), 16'hC000 + 16'(k));
      cycle();
      k++;
    end
    chk("burst_bound", 32'(k < 40), 32'd1);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      cycle();
      k++;
    end
    chk("burst_drained", 32'(sb.size()), 32'd0);
    chk("burst_writes",  32'(n_wr), 32'(n_acc));
    repeat (2) cycle();

    // Fill as deep as the queue goes, then reset in the middle of draining.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'(i), 16'hD000 + 16'(i), 1'b1, 7'(3 - i), 16'hE000 + 16'(i));
      cycle();
    end
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    chk("mid_rst_write_regc", 32'(Write_RegC), 32'd0);
    for (int q = 0; q < NREG; q++) begin
      Query_A = 7'(q);
      Query_B = 7'(q);
      #1;
      chk($sformatf("mid_rst_pend_a%0d", q), 32'(Pend_A), 32'd0);
      chk($sformatf("mid_rst_pend_b%0d", q), 32'(Pend_B), 32'd0);
    end
    chk("mid_rst_alu_ready", 32'(Alu_Ready), 32'd1);
    chk("mid_rst_ld_ready",  32'(Ld_Ready),  32'd1);
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
